vga_timing_gen: RTL and testbench

Parametrised successor to the fixed 640x480 VGA controller. It generates horizontal and vertical timing, sync, blanking and pixel coordinates from a single system clock, using a pixel-enable strobe instead of a derived clock. All porch, sync and active widths, sync polarities, the clock divide ratio and an output alignment delay are parameters. It sits between the system clock and the frame-buffer/ray-tracer pixel pipeline, and drives the video DAC.

---
 rtl/vga_pkg.sv | 52 +++++
 rtl/vga_sync_delay.sv | 34 +++
 rtl/vga_timing_gen.sv | 180 ++++++++++++++++++
 tb/tb_vga_timing_gen.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// rtl/vga_pkg.sv - default 640x480@60 timing, timing struct and region decode
package vga_pkg;

  localparam int VGA_H_ACTIVE = 640;
  localparam int VGA_H_FP     = 16;
  localparam int VGA_H_SYNC   = 96;
  localparam int VGA_H_BP     = 48;
  localparam int VGA_V_ACTIVE = 480;
  localparam int VGA_V_FP     = 10;
  localparam int VGA_V_SYNC   = 2;
  localparam int VGA_V_BP     = 33;

  // Field width of the timing set; counters narrower than this zero-extend.
  localparam int VGA_TW = 16;

  typedef struct packed {
    logic [VGA_TW-1:0] h_active;
    logic [VGA_TW-1:0] h_fp;
    logic [VGA_TW-1:0] h_sync;
    logic [VGA_TW-1:0] h_bp;
    logic [VGA_TW-1:0] v_active;
    logic [VGA_TW-1:0] v_fp;
    logic [VGA_TW-1:0] v_sync;
    logic [VGA_TW-1:0] v_bp;
  } vga_timing_t;

  typedef struct packed {
    logic hs;
    logic vs;
    logic blank;
  } vga_sync_t;

  // Sync levels and display-region flag for one (hc, vc) position.
  function automatic vga_sync_t vga_decode(input logic [31:0] hc, input logic [31:0] vc,
                                           input vga_timing_t t, input logic hs_pol,
                                           input logic vs_pol);
    logic [31:0] hs_beg;
    logic [31:0] hs_end;
    logic [31:0] vs_beg;
    logic [31:0] vs_end;
    vga_sync_t   r;
    hs_beg  = 32'(t.h_active) + 32'(t.h_fp);
    hs_end  = hs_beg + 32'(t.h_sync);
    vs_beg  = 32'(t.v_active) + 32'(t.v_fp);
    vs_end  = vs_beg + 32'(t.v_sync);
    r.hs    = ((hc >= hs_beg) && (hc < hs_end)) ? hs_pol : ~hs_pol;
    r.vs    = ((vc >= vs_beg) && (vc < vs_end)) ? vs_pol : ~vs_pol;
    r.blank = (hc < 32'(t.h_active)) && (vc < 32'(t.v_active));
    return r;
  endfunction

endpackage

// File: rtl/vga_sync_delay.sv
// rtl/vga_sync_delay.sv - enabled shift register for aligning sync/blank or pixel data
module vga_sync_delay #(
  parameter int           W       = 3,
  parameter int           DEPTH   = 0,
  parameter logic [W-1:0] RST_VAL = '0
) (
  input  logic         Clk,
  input  logic         Reset_n,
  input  logic         en,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout
);

  if (DEPTH == 0) begin : g_bypass
    logic unused_ctl;
    assign unused_ctl = ^{Clk, Reset_n, en};
    assign dout = din;
  end else begin : g_shift
    logic [W-1:0] sr [DEPTH];

    // shift one stage per enable, oldest stage drives the output
    always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
        for (int i = 0; i < DEPTH; i++) sr[i] <= RST_VAL;
      end else if (en) begin
        sr[0] <= din;
        for (int i = 1; i < DEPTH; i++) sr[i] <= sr[i-1];
      end
    end

    assign dout = sr[DEPTH-1];
  end

endmodule

// File: rtl/vga_timing_gen.sv
// rtl/vga_timing_gen.sv - parametrised VGA timing generator; VGA_TIMING_PROG_EN adds runtime timing registers
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int H_ACTIVE = VGA_H_ACTIVE,
  parameter int H_FP     = VGA_H_FP,
  parameter int H_SYNC   = VGA_H_SYNC,
  parameter int H_BP     = VGA_H_BP,
  parameter int V_ACTIVE = VGA_V_ACTIVE,
  parameter int V_FP     = VGA_V_FP,
  parameter int V_SYNC   = VGA_V_SYNC,
  parameter int V_BP     = VGA_V_BP,
  parameter int CLK_DIV  = 4,
  parameter bit HS_POL   = 1'b0,
  parameter bit VS_POL   = 1'b0,
  parameter int PIPE_DLY = 0,
  parameter int CNT_W    = 11
) (
  input  logic             Clk,
  input  logic             Reset_n,
  input  logic             en,
  output logic             pix_en,
  output logic             hs,
  output logic             vs,
  output logic             blank,
  output logic             sync,
  output logic [CNT_W-1:0] DrawX,
  output logic [CNT_W-1:0] DrawY,
  output logic             line_start,
  output logic             frame_start
`ifdef VGA_TIMING_PROG_EN
  ,
  input  logic             cfg_we,
  input  logic [2:0]       cfg_addr,
  input  logic [CNT_W-1:0] cfg_wdata,
  output logic             cfg_pending
`endif
);

  localparam int H_TOTAL_P = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL_P = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int DIV_W     = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  if (H_TOTAL_P > (1 << CNT_W) || V_TOTAL_P > (1 << CNT_W)) begin : g_total_chk
    $error("vga_timing_gen: line or frame total does not fit in CNT_W bits");
  end
  if (CNT_W > VGA_TW || CLK_DIV < 1 || PIPE_DLY < 0 || PIPE_DLY > 7) begin : g_param_chk
    $error("vga_timing_gen: CNT_W, CLK_DIV or PIPE_DLY out of range");
  end

  localparam vga_timing_t TIMING_P = '{
    h_active: VGA_TW'(H_ACTIVE), h_fp: VGA_TW'(H_FP), h_sync: VGA_TW'(H_SYNC),
    h_bp: VGA_TW'(H_BP), v_active: VGA_TW'(V_ACTIVE), v_fp: VGA_TW'(V_FP),
    v_sync: VGA_TW'(V_SYNC), v_bp: VGA_TW'(V_BP)};

  // Reset pattern of the first sync stage describes (0,0); the delay line
  // starts blanked so nothing is displayed before real data reaches it.
  localparam vga_sync_t SYNC_RST = '{hs: ~HS_POL, vs: ~VS_POL, blank: 1'b1};
  localparam vga_sync_t DLY_RST  = '{hs: ~HS_POL, vs: ~VS_POL, blank: 1'b0};

  vga_timing_t      act;
  logic [31:0]      h_total;
  logic [31:0]      v_total;
  logic [CNT_W-1:0] h_last;
  logic [CNT_W-1:0] v_last;
  logic [DIV_W-1:0] div;
  logic [CNT_W-1:0] hc;
  logic [CNT_W-1:0] vc;
  logic [CNT_W-1:0] hc_next;
  logic [CNT_W-1:0] vc_next;
  logic             wrap_frame;
  vga_sync_t        sync_nxt;
  vga_sync_t        sync_cur;
  logic [2:0]       sync_out;

  assign h_total = 32'(act.h_active) + 32'(act.h_fp) + 32'(act.h_sync) + 32'(act.h_bp);
  assign v_total = 32'(act.v_active) + 32'(act.v_fp) + 32'(act.v_sync) + 32'(act.v_bp);
  assign h_last  = CNT_W'(h_total - 32'd1);
  assign v_last  = CNT_W'(v_total - 32'd1);

  assign pix_en  = en && (div == DIV_LAST);

  // pixel divider, frozen while en is low
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      div <= '0;
    end else if (en) begin
      div <= (div == DIV_LAST) ? '0 : div + DIV_W'(1);
    end
  end

  // next horizontal/vertical position, advancing once per pixel period
  always_comb begin
    hc_next = hc;
    vc_next = vc;
    if (pix_en) begin
      if (hc == h_last) begin
        hc_next = '0;
        vc_next = (vc == v_last) ? '0 : vc + CNT_W'(1);
      end else begin
        hc_next = hc + CNT_W'(1);
      end
    end
  end

  assign wrap_frame = pix_en && (hc_next == '0) && (vc_next == '0);

  // Decoding the next position keeps the registered sync aligned with DrawX/DrawY.
  assign sync_nxt = vga_decode(32'(hc_next), 32'(vc_next), act, HS_POL, VS_POL);

  // counters, first sync stage and start pulses
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      hc          <= '0;
      vc          <= '0;
      sync_cur    <= SYNC_RST;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else if (en) begin
      hc          <= hc_next;
      vc          <= vc_next;
      if (pix_en) sync_cur <= sync_nxt;
      line_start  <= pix_en && (hc_next == '0);
      frame_start <= wrap_frame;
    end
  end

  vga_sync_delay #(
    .W      (3),
    .DEPTH  (PIPE_DLY),
    .RST_VAL(DLY_RST)
  ) u_sync_delay (
    .Clk    (Clk),
    .Reset_n(Reset_n),
    .en     (pix_en),
    .din    (sync_cur),
    .dout   (sync_out)
  );

  assign {hs, vs, blank} = sync_out;
  assign sync  = 1'b0;
  assign DrawX = hc;
  assign DrawY = vc;

`ifdef VGA_TIMING_PROG_EN
  vga_timing_t shadow;

  // shadow writes; the shadow set becomes active on the frame wrap edge
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      shadow      <= TIMING_P;
      act         <= TIMING_P;
      cfg_pending <= 1'b0;
    end else begin
      if (wrap_frame) act <= shadow;
      if (cfg_we) begin
        case (cfg_addr)
          3'd0: shadow.h_active <= VGA_TW'(cfg_wdata);
          3'd1: shadow.h_fp     <= VGA_TW'(cfg_wdata);
          3'd2: shadow.h_sync   <= VGA_TW'(cfg_wdata);
          3'd3: shadow.h_bp     <= VGA_TW'(cfg_wdata);
          3'd4: shadow.v_active <= VGA_TW'(cfg_wdata);
          3'd5: shadow.v_fp     <= VGA_TW'(cfg_wdata);
          3'd6: shadow.v_sync   <= VGA_TW'(cfg_wdata);
          3'd7: shadow.v_bp     <= VGA_TW'(cfg_wdata);
        endcase
      end
      if (cfg_we) begin
        cfg_pending <= 1'b1;
      end else if (wrap_frame) begin
        cfg_pending <= 1'b0;
      end
    end
  end
`else
  assign act = TIMING_P;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb/tb_vga_timing_gen.sv - directed checks of vga_timing_gen across four configurations
module tb_vga_timing_gen;

  logic Clk = 1'b0;
  always #5 Clk = ~Clk;

  logic rst_n0, rst_n, en0, en;

  logic pe0, hs0, vs0, bl0, sy0, ls0, fs0;
  logic [10:0] x0, y0;
  logic pe1, hs1, vs1, unused_bl1, unused_sy1, ls1, unused_fs1;
  logic [10:0] x1, y1;
  logic unused_pe2, hs2, unused_vs2, bl2, unused_sy2, unused_ls2, unused_fs2;
  logic [10:0] x2, y2;
  logic unused_pe3, unused_hs3, vs3, bl3, unused_sy3, ls3, fs3;
  logic [4:0] x3, y3;

`ifdef VGA_TIMING_PROG_EN
  logic       pend0, pend1, pend2, pend3;
  logic       cfg_we3;
  logic [2:0] cfg_addr3;
  logic [4:0] cfg_wdata3;
`endif

  vga_timing_gen u0 (
    .Clk(Clk), .Reset_n(rst_n0), .en(en0), .pix_en(pe0), .hs(hs0), .vs(vs0),
    .blank(bl0), .sync(sy0), .DrawX(x0), .DrawY(y0), .line_start(ls0), .frame_start(fs0)
`ifdef VGA_TIMING_PROG_EN
    , .cfg_we(1'b0), .cfg_addr(3'd0), .cfg_wdata(11'd0), .cfg_pending(pend0)
`endif
  );

  vga_timing_gen #(.HS_POL(1'b1), .VS_POL(1'b1), .CLK_DIV(1)) u1 (
    .Clk(Clk), .Reset_n(rst_n), .en(en), .pix_en(pe1), .hs(hs1), .vs(vs1),
    .blank(unused_bl1), .sync(unused_sy1), .DrawX(x1), .DrawY(y1), .line_start(ls1),
    .frame_start(unused_fs1)
`ifdef VGA_TIMING_PROG_EN
    , .cfg_we(1'b0), .cfg_addr(3'd0), .cfg_wdata(11'd0), .cfg_pending(pend1)
`endif
  );

  vga_timing_gen #(.PIPE_DLY(2)) u2 (
    .Clk(Clk), .Reset_n(rst_n), .en(en), .pix_en(unused_pe2), .hs(hs2), .vs(unused_vs2),
    .blank(bl2), .sync(unused_sy2), .DrawX(x2), .DrawY(y2), .line_start(unused_ls2),
    .frame_start(unused_fs2)
`ifdef VGA_TIMING_PROG_EN
    , .cfg_we(1'b0), .cfg_addr(3'd0), .cfg_wdata(11'd0), .cfg_pending(pend2)
`endif
  );

  vga_timing_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .CLK_DIV(2), .CNT_W(5)
  ) u3 (
    .Clk(Clk), .Reset_n(rst_n), .en(en), .pix_en(unused_pe3), .hs(unused_hs3), .vs(vs3),
    .blank(bl3), .sync(unused_sy3), .DrawX(x3), .DrawY(y3), .line_start(ls3), .frame_start(fs3)
`ifdef VGA_TIMING_PROG_EN
    , .cfg_we(cfg_we3), .cfg_addr(cfg_addr3), .cfg_wdata(cfg_wdata3), .cfg_pending(pend3)
`endif
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  int first_pe0 = -1, first_x1_0 = -1, hs_first0 = -1, hs_low0 = 0, bl_first0 = -1;
  int ls_cnt0 = 0, ls_cyc0 = -1, fs_cnt0 = 0;
  int pe1_low = 0, hs_first1 = -1, hs_hi1 = 0, ls1_a = -1, ls1_b = -1;
  int bl2_x1 = -1, bl2_x2 = -1, bl_first2 = -1, hs_first2 = -1;
  int ls_cnt3 = 0, vs_min3 = 99, vs_max3 = -1, ymax3 = -1, fs_cnt3 = 0;
  int fs3_a = -1, fs3_b = -1, fs3_x = -1, fs3_y = -1, fs3_ls = -1;
  int frz_pe = 0, edges = 0;

  initial begin
`ifdef VGA_TIMING_PROG_EN
    cfg_we3 = 1'b0; cfg_addr3 = 3'd0; cfg_wdata3 = 5'd0;
`endif
    rst_n0 = 1'b0; rst_n = 1'b0; en0 = 1'b1; en = 1'b1;
    repeat (3) @(negedge Clk);

    check("rst_x0", 32'(x0), 0);
    check("rst_y0", 32'(y0), 0);
    check("rst_hs0", 32'(hs0), 1);
    check("rst_vs0", 32'(vs0), 1);
    check("rst_blank0", 32'(bl0), 1);
    check("rst_pix_en0", 32'(pe0), 0);
    check("rst_line_start0", 32'(ls0), 0);
    check("rst_frame_start0", 32'(fs0), 0);
    check("sync_tied0", 32'(sy0), 0);
    check("rst_hs1_pol", 32'(hs1), 0);
    check("rst_vs1_pol", 32'(vs1), 0);
    check("rst_blank2_dly", 32'(bl2), 0);
    check("rst_hs2_dly", 32'(hs2), 1);
`ifdef VGA_TIMING_PROG_EN
    check("rst_cfg_pending", 32'(pend3), 0);
`endif

    rst_n0 = 1'b1; rst_n = 1'b1;
    for (int c = 1; c <= 3300; c++) begin
      @(posedge Clk);
      @(negedge Clk);
      if (pe0 && first_pe0 < 0) first_pe0 = c;
      if (x0 == 11'd1 && first_x1_0 < 0) first_x1_0 = c;
      if (pe0 && y0 == 11'd0 && !hs0) begin
        hs_low0++;
        if (hs_first0 < 0) hs_first0 = int'(x0);
      end
      if (!bl0 && bl_first0 < 0) bl_first0 = int'(x0);
      if (ls0) begin ls_cnt0++; ls_cyc0 = c; end
      if (fs0) fs_cnt0++;

      if (!pe1) pe1_low++;
      if (y1 == 11'd0 && hs1) begin
        hs_hi1++;
        if (hs_first1 < 0) hs_first1 = int'(x1);
      end
      if (ls1) begin
        if (ls1_a < 0) ls1_a = c;
        else if (ls1_b < 0) ls1_b = c;
      end

      if (y2 == 11'd0) begin
        if (x2 == 11'd1 && bl2_x1 < 0) bl2_x1 = int'(bl2);
        if (x2 == 11'd2 && bl2_x2 < 0) bl2_x2 = int'(bl2);
        if (x2 >= 11'd2 && !bl2 && bl_first2 < 0) bl_first2 = int'(x2);
        if (!hs2 && hs_first2 < 0) hs_first2 = int'(x2);
      end

      if (c <= 256) begin
        if (ls3) ls_cnt3++;
        if (!vs3) begin
          if (int'(y3) < vs_min3) vs_min3 = int'(y3);
          if (int'(y3) > vs_max3) vs_max3 = int'(y3);
        end
        if (int'(y3) > ymax3) ymax3 = int'(y3);
      end
      if (fs3) begin
        fs_cnt3++;
        if (fs3_a < 0) begin
          fs3_a = c; fs3_x = int'(x3); fs3_y = int'(y3); fs3_ls = int'(ls3);
        end else if (fs3_b < 0) begin
          fs3_b = c;
        end
      end
    end

    check("first_pix_en_edges", first_pe0, 3);
    check("first_drawx1_edges", first_x1_0, 4);
    check("hs0_first_low_x", hs_first0, 656);
    check("hs0_low_pixels", hs_low0, 96);
    check("blank0_fall_x", bl_first0, 640);
    check("line_period0", ls_cyc0, 3200);
    check("line_start0_width", ls_cnt0, 1);
    check("no_frame_start0", fs_cnt0, 0);
    check("pix_en1_always", pe1_low, 0);
    check("hs1_first_high_x", hs_first1, 656);
    check("hs1_high_pixels", hs_hi1, 96);
    check("line_start1_first", ls1_a, 800);
    check("line_period1", ls1_b - ls1_a, 800);
    check("blank2_x1_reset_pat", bl2_x1, 0);
    check("blank2_x2", bl2_x2, 1);
    check("blank2_fall_x", bl_first2, 642);
    check("hs2_first_low_x", hs_first2, 658);
    check("line_starts3_frame", ls_cnt3, 8);
    check("vs3_first_line", vs_min3, 5);
    check("vs3_last_line", vs_max3, 6);
    check("drawy3_max", ymax3, 7);
    check("frame_start3_first", fs3_a, 256);
    check("frame_period3", fs3_b - fs3_a, 256);
    check("frame_wrap3_x", fs3_x, 0);
    check("frame_wrap3_y", fs3_y, 0);
    check("frame_wrap3_line_start", fs3_ls, 1);
    check("frame_starts3_count", fs_cnt3, 12);

    for (int k = 0; k < 4000 && x0 != 11'd100; k++) @(negedge Clk);
    check("wait_x100", 32'(x0), 100);
    en0 = 1'b0;
    for (int k = 0; k < 50; k++) begin
      @(negedge Clk);
      if (pe0) frz_pe++;
    end
    check("freeze_pix_en", frz_pe, 0);
    check("freeze_x", 32'(x0), 100);
    check("freeze_y", 32'(y0), 1);
    check("freeze_hs", 32'(hs0), 1);
    check("freeze_vs", 32'(vs0), 1);
    check("freeze_blank", 32'(bl0), 1);
    en0 = 1'b1;
    for (int k = 0; k < 20 && x0 == 11'd100; k++) @(negedge Clk);
    check("resume_x", 32'(x0), 101);

    for (int k = 0; k < 4000 && x0 != 11'd700; k++) @(negedge Clk);
    check("wait_x700", 32'(x0), 700);
    check("pre_rst_hs", 32'(hs0), 0);
    check("pre_rst_blank", 32'(bl0), 0);
    rst_n0 = 1'b0;
    #1;
    check("async_rst_x", 32'(x0), 0);
    check("async_rst_y", 32'(y0), 0);
    check("async_rst_hs", 32'(hs0), 1);
    check("async_rst_blank", 32'(bl0), 1);
    check("async_rst_pix_en", 32'(pe0), 0);
    repeat (2) @(negedge Clk);
    rst_n0 = 1'b1;
    for (int k = 0; k < 10 && x0 != 11'd1; k++) begin
      @(posedge Clk);
      @(negedge Clk);
      edges++;
    end
    check("post_rst_x1_edges", edges, 4);
    check("post_rst_y", 32'(y0), 0);

`ifdef VGA_TIMING_PROG_EN
    for (int k = 0; k < 600 && y3 != 5'd2; k++) @(negedge Clk);
    cfg_we3 = 1'b1; cfg_addr3 = 3'd0; cfg_wdata3 = 5'd4;
    @(negedge Clk);
    cfg_we3 = 1'b0;
    check("cfg_pending_set", 32'(pend3), 1);
    for (int k = 0; k < 600 && !(y3 == 5'd3 && x3 == 5'd0); k++) @(negedge Clk);
    for (int k = 0; k < 100 && bl3; k++) @(negedge Clk);
    check("old_blank_fall_x", 32'(x3), 8);
    for (int k = 0; k < 600 && !fs3; k++) @(negedge Clk);
    check("cfg_frame_start", 32'(fs3), 1);
    check("cfg_pending_clear", 32'(pend3), 0);
    for (int k = 0; k < 100 && bl3; k++) @(negedge Clk);
    check("new_blank_fall_x", 32'(x3), 4);
`endif

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
